// File: rtl/dma_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dma_reg_pkg
//  Description : Shared types and sizing for the DMA request/priority arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package dma_reg_pkg;

   localparam int DMA_NUM_CH = 4;
   localparam int DMA_CH_W   = $clog2(DMA_NUM_CH);

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_REQ     = 2'd1,
      ARB_GRANT   = 2'd2,
      ARB_RELEASE = 2'd3
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/dma_priority_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dma_priority_arbiter_if
//  Description : Request, hold-handshake and grant signals of the DMA arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface dma_priority_arbiter_if
   import dma_reg_pkg::*;
#(
   parameter int NUM_CH = DMA_NUM_CH,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) ();

   logic [NUM_CH-1:0] dreq;
   logic              hlda;
   logic              dma_en;
   logic              priority_type;
   logic              dreq_sense;
   logic              dack_sense;
   logic [NUM_CH-1:0] mask_bits;
   logic [NUM_CH-1:0] sw_req;
   logic              svc_done;
   logic              hrq;
   logic [NUM_CH-1:0] dack;
   logic              grant_valid;
   logic [CH_W-1:0]   grant_ch;
   logic [NUM_CH-1:0] sw_req_clr;

   modport slave (
      input  dreq, hlda, dma_en, priority_type, dreq_sense, dack_sense,
             mask_bits, sw_req, svc_done,
      output hrq, dack, grant_valid, grant_ch, sw_req_clr
   );

   modport master (
      output dreq, hlda, dma_en, priority_type, dreq_sense, dack_sense,
             mask_bits, sw_req, svc_done,
      input  hrq, dack, grant_valid, grant_ch, sw_req_clr
   );

endinterface
`default_nettype wire

// File: rtl/dma_prio_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : dma_prio_encoder
//  Description : Combinational fixed/rotating priority encoder; the search
//                starts at ptr_i when rotate_en_i is set, else at channel 0.
//  Revision    : 1.0  initial release
// ============================================================================
module dma_prio_encoder
   import dma_reg_pkg::*;
#(
   parameter int NUM_CH = DMA_NUM_CH,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [CH_W-1:0]   ptr_i,
   input  logic              rotate_en_i,
   output logic              any_o,
   output logic [CH_W-1:0]   idx_o
);

   logic [CH_W-1:0] base;
   logic [CH_W-1:0] cand;
   logic            found;

   always_comb begin
      base  = rotate_en_i ? ptr_i : '0;
      any_o = |req_i;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         int c;
         c = int'(base) + k;
         if (c >= NUM_CH) begin
            c = c - NUM_CH;
         end
         cand = CH_W'(c);
         if (!found && req_i[cand]) begin
            idx_o = cand;
            found = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dma_priority_arbiter
//  Description : DMA request resolver: merges DREQ/software requests, runs the
//                HRQ/HLDA hold handshake and drives DACK to the winning channel.
//                Option DMA_DREQ_SYNC_EN adds a 2-flop DREQ synchronizer.
//  Revision    : 1.0  initial release
// ============================================================================
module dma_priority_arbiter
   import dma_reg_pkg::*;
#(
   parameter int NUM_CH = DMA_NUM_CH
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   dma_priority_arbiter_if.slave  bus
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] dreq_pol;
   logic [NUM_CH-1:0] dreq_act;
   logic [NUM_CH-1:0] pending;
   logic              pend_any;
   logic [CH_W-1:0]   win_idx;

   arb_state_t        state_q, state_d;
   logic              hrq_q, hrq_d;
   logic [NUM_CH-1:0] dack_q, dack_d;
   logic              grant_valid_q, grant_valid_d;
   logic [CH_W-1:0]   grant_ch_q, grant_ch_d;
   logic [NUM_CH-1:0] sw_req_clr_q, sw_req_clr_d;
   logic [CH_W-1:0]   ptr_q, ptr_d;

   // Polarity is removed before synchronizing so reset-zero flops read as "no request".
   assign dreq_pol = bus.dreq ^ {NUM_CH{bus.dreq_sense}};

`ifdef DMA_DREQ_SYNC_EN
   logic [NUM_CH-1:0] sync1_q;
   logic [NUM_CH-1:0] sync2_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= dreq_pol;
         sync2_q <= sync1_q;
      end
   end

   assign dreq_act = sync2_q;
`else
   assign dreq_act = dreq_pol;
`endif

   // Software requests are not subject to the channel mask.
   assign pending = (dreq_act & ~bus.mask_bits) | bus.sw_req;

   dma_prio_encoder #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_enc (
      .req_i       (pending),
      .ptr_i       (ptr_q),
      .rotate_en_i (bus.priority_type),
      .any_o       (pend_any),
      .idx_o       (win_idx)
   );

   always_comb begin
      state_d       = state_q;
      hrq_d         = hrq_q;
      dack_d        = dack_q;
      grant_valid_d = grant_valid_q;
      grant_ch_d    = grant_ch_q;
      sw_req_clr_d  = '0;
      ptr_d         = ptr_q;
      case (state_q)
         ARB_IDLE: begin
            if (bus.dma_en && pend_any) begin
               state_d = ARB_REQ;
               hrq_d   = 1'b1;
            end
         end
         ARB_REQ: begin
            if (!pend_any) begin
               state_d = ARB_IDLE;
               hrq_d   = 1'b0;
            end else if (bus.hlda) begin
               state_d       = ARB_GRANT;
               grant_ch_d    = win_idx;
               grant_valid_d = 1'b1;
               dack_d        = NUM_CH'(1) << win_idx;
            end
         end
         ARB_GRANT: begin
            // Completion wins over a simultaneous HLDA drop.
            if (bus.svc_done) begin
               state_d       = ARB_RELEASE;
               hrq_d         = 1'b0;
               dack_d        = '0;
               grant_valid_d = 1'b0;
               sw_req_clr_d  = NUM_CH'(1) << grant_ch_q;
               ptr_d         = (grant_ch_q == CH_W'(NUM_CH - 1)) ? '0
                                                                 : grant_ch_q + CH_W'(1);
            end else if (!bus.hlda) begin
               state_d       = ARB_IDLE;
               hrq_d         = 1'b0;
               dack_d        = '0;
               grant_valid_d = 1'b0;
            end
         end
         ARB_RELEASE: begin
            if (!bus.hlda) begin
               state_d = ARB_IDLE;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= ARB_IDLE;
         hrq_q         <= 1'b0;
         dack_q        <= '0;
         grant_valid_q <= 1'b0;
         grant_ch_q    <= '0;
         sw_req_clr_q  <= '0;
         ptr_q         <= '0;
      end else begin
         state_q       <= state_d;
         hrq_q         <= hrq_d;
         dack_q        <= dack_d;
         grant_valid_q <= grant_valid_d;
         grant_ch_q    <= grant_ch_d;
         sw_req_clr_q  <= sw_req_clr_d;
         ptr_q         <= ptr_d;
      end
   end

   assign bus.hrq         = hrq_q;
   assign bus.dack        = dack_q ^ {NUM_CH{~bus.dack_sense}};
   assign bus.grant_valid = grant_valid_q;
   assign bus.grant_ch    = grant_ch_q;
   assign bus.sw_req_clr  = sw_req_clr_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_priority_arbiter
//  Description : Self-checking bench for dma_priority_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dma_priority_arbiter;
   import dma_reg_pkg::*;

   localparam int N = 4;
`ifdef DMA_DREQ_SYNC_EN
   localparam int DREQ_LAT = 3;
`else
   localparam int DREQ_LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   model_ptr = 0;

   dma_priority_arbiter_if #(.NUM_CH(N)) bus ();

   dma_priority_arbiter #(.NUM_CH(N)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: first pending channel scanning upward from the start point.
   function automatic int model_winner(input logic [N-1:0] pend, input bit rot, input int ptr);
      int start;
      start = rot ? ptr : 0;
      for (int k = 0; k < N; k++) begin
         int c;
         c = (start + k) % N;
         if (pend[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] dack_pin(input int ch, input bit sense);
      logic [N-1:0] oh;
      oh = '0;
      if (ch >= 0) oh[ch] = 1'b1;
      return sense ? oh : ~oh;
   endfunction

   task automatic wait_hrq(input string tag, output int n);
      n = 0;
      while (bus.hrq !== 1'b1 && n < 12) begin
         tick();
         n++;
      end
      chk({tag, "_hrq_up"}, 32'(bus.hrq), 32'd1);
   endtask

   task automatic grant_and_service(input string tag, input int ch);
      logic [N-1:0] oh;
      oh = '0;
      if (ch >= 0) oh[ch] = 1'b1;
      bus.hlda = 1'b1;
      tick();
      chk({tag, "_gvalid"}, 32'(bus.grant_valid), 32'd1);
      chk({tag, "_grant_ch"}, 32'(bus.grant_ch), 32'(ch));
      chk({tag, "_dack"}, 32'(bus.dack), 32'(dack_pin(ch, bus.dack_sense)));
      bus.svc_done = 1'b1;
      tick();
      chk({tag, "_dack_off"}, 32'(bus.dack), 32'(dack_pin(-1, bus.dack_sense)));
      chk({tag, "_hrq_off"}, 32'(bus.hrq), 32'd0);
      chk({tag, "_clr"}, 32'(bus.sw_req_clr), 32'(oh));
      model_ptr = (ch + 1) % N;
      bus.svc_done = 1'b0;
      bus.hlda     = 1'b0;
      tick();
      chk({tag, "_clr_pulse"}, 32'(bus.sw_req_clr), 32'd0);
   endtask

   task automatic settle(input string tag);
      bus.dreq     = {N{bus.dreq_sense}};
      bus.sw_req   = '0;
      bus.hlda     = 1'b0;
      bus.svc_done = 1'b0;
      repeat (6) tick();
      chk({tag, "_idle_hrq"}, 32'(bus.hrq), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_ptr = 0;
      tick();
   endtask

   initial begin
      int n;
      int exp_ch;
      logic [N-1:0] act, msk, swr, pend;
      bit rot, dsense, ksense, abort;

      bus.dreq = '0;          bus.hlda = 1'b0;       bus.dma_en = 1'b1;
      bus.priority_type = 0;  bus.dreq_sense = 1'b0; bus.dack_sense = 1'b0;
      bus.mask_bits = '0;     bus.sw_req = '0;       bus.svc_done = 1'b0;
      tick();
      tick();
      chk("rst_hrq", 32'(bus.hrq), 32'd0);
      chk("rst_dack", 32'(bus.dack), 32'hF);
      chk("rst_gvalid", 32'(bus.grant_valid), 32'd0);
      chk("rst_grant_ch", 32'(bus.grant_ch), 32'd0);
      chk("rst_clr", 32'(bus.sw_req_clr), 32'd0);
      rst = 1'b0;
      tick();

      // Fixed priority, DREQ latency
      bus.dreq = 4'b1010;
      wait_hrq("fix", n);
      chk("fix_dreq_lat", 32'(n), 32'(DREQ_LAT));
      grant_and_service("fix", model_winner(4'b1010, 1'b0, model_ptr));
      settle("fix");

      // Rotating then fixed with all channels requesting
      do_reset();
      bus.priority_type = 1'b1;
      bus.dreq = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_hrq("rot", n);
         grant_and_service("rot", model_winner(4'b1111, 1'b1, model_ptr));
      end
      bus.priority_type = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_hrq("fixall", n);
         grant_and_service("fixall", model_winner(4'b1111, 1'b0, model_ptr));
      end
      settle("rot");

      // Mask blocks DREQ; software request bypasses it
      bus.mask_bits = 4'b0001;
      bus.dreq = 4'b0001;
      repeat (DREQ_LAT + 3) tick();
      chk("mask_hrq", 32'(bus.hrq), 32'd0);
      bus.sw_req = 4'b0001;
      wait_hrq("swreq", n);
      chk("swreq_lat", 32'(n), 32'd1);
      grant_and_service("swreq", model_winner(4'b0001, 1'b0, model_ptr));
      bus.mask_bits = '0;
      settle("swreq");

      // Abort: HLDA drop in GRANT, pointer must not move
      do_reset();
      bus.priority_type = 1'b1;
      bus.dreq = 4'b0110;
      wait_hrq("abort", n);
      exp_ch = model_winner(4'b0110, 1'b1, model_ptr);
      bus.hlda = 1'b1;
      tick();
      chk("abort_grant_ch", 32'(bus.grant_ch), 32'(exp_ch));
      bus.hlda = 1'b0;
      tick();
      chk("abort_dack", 32'(bus.dack), 32'hF);
      chk("abort_gvalid", 32'(bus.grant_valid), 32'd0);
      chk("abort_hrq", 32'(bus.hrq), 32'd0);
      chk("abort_clr", 32'(bus.sw_req_clr), 32'd0);
      for (int i = 0; i < 2; i++) begin
         wait_hrq("postabort", n);
         grant_and_service("postabort", model_winner(4'b0110, 1'b1, model_ptr));
      end
      settle("abort");

      // Withdrawal in REQ, and dma_en gating
      bus.dreq = 4'b0100;
      wait_hrq("wdraw", n);
      bus.dreq = '0;
      repeat (DREQ_LAT) tick();
      chk("wdraw_hrq", 32'(bus.hrq), 32'd0);
      bus.dma_en = 1'b0;
      bus.dreq = 4'b0100;
      repeat (DREQ_LAT + 3) tick();
      chk("dis_hrq", 32'(bus.hrq), 32'd0);
      bus.dma_en = 1'b1;
      wait_hrq("reen", n);
      settle("dis");

      // Inverted polarities, then async reset mid-GRANT
      do_reset();
      bus.priority_type = 1'b0;
      bus.dreq_sense = 1'b1;
      bus.dack_sense = 1'b1;
      bus.dreq = 4'b1011;
      wait_hrq("pol", n);
      exp_ch = model_winner(~4'b1011, 1'b0, model_ptr);
      bus.hlda = 1'b1;
      tick();
      chk("pol_grant_ch", 32'(bus.grant_ch), 32'(exp_ch));
      chk("pol_dack", 32'(bus.dack), 32'(dack_pin(exp_ch, 1'b1)));
      bus.dack_sense = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      chk("arst_hrq", 32'(bus.hrq), 32'd0);
      chk("arst_dack", 32'(bus.dack), 32'hF);
      chk("arst_gvalid", 32'(bus.grant_valid), 32'd0);
      bus.hlda = 1'b0;
      tick();
      rst = 1'b0;
      model_ptr = 0;
      settle("arst");

      // Randomized transactions against the reference model
      for (int it = 0; it < 24; it++) begin
         act    = 4'($urandom);
         msk    = 4'($urandom);
         swr    = ($urandom % 3 == 0) ? 4'($urandom) : 4'b0000;
         pend   = (act & ~msk) | swr;
         if (pend == '0) begin
            swr  = 4'b0001 << $urandom_range(0, 3);
            pend = swr;
         end
         rot    = 1'($urandom);
         dsense = 1'($urandom);
         ksense = 1'($urandom);
         abort  = ($urandom % 4 == 0);
         bus.dreq_sense    = dsense;
         bus.dack_sense    = ksense;
         bus.dreq          = act ^ {N{dsense}};
         bus.mask_bits     = msk;
         bus.sw_req        = swr;
         bus.priority_type = rot;
         wait_hrq("rnd", n);
         repeat (2) tick();
         exp_ch = model_winner(pend, rot, model_ptr);
         bus.hlda = 1'b1;
         tick();
         chk("rnd_grant_ch", 32'(bus.grant_ch), 32'(exp_ch));
         chk("rnd_dack", 32'(bus.dack), 32'(dack_pin(exp_ch, ksense)));
         if (abort) begin
            bus.hlda = 1'b0;
            tick();
            chk("rnd_abort_clr", 32'(bus.sw_req_clr), 32'd0);
         end else begin
            bus.svc_done = 1'b1;
            bus.dreq     = {N{dsense}};
            tick();
            chk("rnd_clr", 32'(bus.sw_req_clr), 32'(4'b0001 << exp_ch));
            model_ptr = (exp_ch + 1) % N;
         end
         chk("rnd_dack_off", 32'(bus.dack), 32'(dack_pin(-1, ksense)));
         settle("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
